lsu_wb_pipe: RTL and testbench

LSU_WB_PIPE -- requirements
Module: lsu_wb_pipe

---
 rtl/lsu_wb_pipe.sv | 153 +++++++++++++++
 tb/tb_lsu_wb_pipe.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/lsu_wb_pipe.sv
// LSU-to-writeback pipeline register: a two-entry (MAIN + SKID) buffer with a registered ready,
// GPR/CSR write gating, a retire pulse and a retired-instruction counter.
module lsu_wb_pipe #(
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned GPR_AW      = 5,
  parameter int unsigned CSR_AW      = 12,
  parameter int unsigned CNT_W       = 64,
  parameter bit          X0_SUPPRESS = 1'b1
) (
  input  logic              clk_i,
  input  logic              n_rst_i,
  input  logic              flush_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic              rd_we_i,
  input  logic [GPR_AW-1:0] rd_wa_i,
  input  logic [DATA_W-1:0] rd_wd_i,
  input  logic              csr_we_i,
  input  logic [CSR_AW-1:0] csr_wa_i,
  input  logic [DATA_W-1:0] csr_wd_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic              rd_we_o,
  output logic [GPR_AW-1:0] rd_wa_o,
  output logic [DATA_W-1:0] rd_wd_o,
  output logic              csr_we_o,
  output logic [CSR_AW-1:0] csr_wa_o,
  output logic [DATA_W-1:0] csr_wd_o,
  output logic              instret_incr_o,
  output logic [CNT_W-1:0]  retired_cnt_o,
  output logic [1:0]        occupancy_o
);

  typedef enum logic [1:0] {
    StEmpty = 2'd0,
    StOne   = 2'd1,
    StTwo   = 2'd2
  } state_e;

  typedef struct packed {
    logic              rd_we;
    logic [GPR_AW-1:0] rd_wa;
    logic [DATA_W-1:0] rd_wd;
    logic              csr_we;
    logic [CSR_AW-1:0] csr_wa;
    logic [DATA_W-1:0] csr_wd;
  } entry_t;

  localparam logic [CNT_W-1:0] CntOne = {{(CNT_W-1){1'b0}}, 1'b1};

  state_e           state_q, state_d;
  entry_t           main_q, main_d;
  entry_t           skid_q, skid_d;
  entry_t           in_entry;
  logic             in_ready_q, in_ready_d;
  logic [CNT_W-1:0] retired_cnt_q, retired_cnt_d;
  logic             in_fire;
  logic             out_fire;
  logic             rd_x0;

  assign in_entry = '{
    rd_we:  rd_we_i,
    rd_wa:  rd_wa_i,
    rd_wd:  rd_wd_i,
    csr_we: csr_we_i,
    csr_wa: csr_wa_i,
    csr_wd: csr_wd_i
  };

  assign out_valid_o = (state_q != StEmpty);
  assign in_fire     = in_valid_i & in_ready_q;
  assign out_fire    = out_valid_o & out_ready_i;

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    if (flush_i) begin
      // Data bits may stay stale; only enables and addresses must be cleared.
      state_d       = StEmpty;
      main_d.rd_we  = 1'b0;
      main_d.rd_wa  = '0;
      main_d.csr_we = 1'b0;
      main_d.csr_wa = '0;
      skid_d.rd_we  = 1'b0;
      skid_d.rd_wa  = '0;
      skid_d.csr_we = 1'b0;
      skid_d.csr_wa = '0;
    end else begin
      unique case (state_q)
        StEmpty: begin
          if (in_fire) begin
            state_d = StOne;
            main_d  = in_entry;
          end
        end
        StOne: begin
          if (in_fire && out_fire) begin
            main_d = in_entry;
          end else if (in_fire) begin
            state_d = StTwo;
            skid_d  = in_entry;
          end else if (out_fire) begin
            state_d = StEmpty;
          end
        end
        StTwo: begin
          // in_ready is low here, so no input can arrive alongside the drain.
          if (out_fire) begin
            state_d = StOne;
            main_d  = skid_q;
          end
        end
        default: state_d = StEmpty;
      endcase
    end
  end

  always_comb begin
    in_ready_d    = (state_d != StTwo);
    retired_cnt_d = out_fire ? (retired_cnt_q + CntOne) : retired_cnt_q;
  end

  always_ff @(posedge clk_i or negedge n_rst_i) begin
    if (!n_rst_i) begin
      state_q       <= StEmpty;
      main_q        <= '0;
      skid_q        <= '0;
      in_ready_q    <= 1'b0;
      retired_cnt_q <= '0;
    end else begin
      state_q       <= state_d;
      main_q        <= main_d;
      skid_q        <= skid_d;
      in_ready_q    <= in_ready_d;
      retired_cnt_q <= retired_cnt_d;
    end
  end

  assign rd_x0 = X0_SUPPRESS && (main_q.rd_wa == '0);

  assign in_ready_o     = in_ready_q;
  assign rd_we_o        = out_valid_o & main_q.rd_we & ~rd_x0;
  assign rd_wa_o        = main_q.rd_wa;
  assign rd_wd_o        = main_q.rd_wd;
  assign csr_we_o       = out_valid_o & main_q.csr_we;
  assign csr_wa_o       = main_q.csr_wa;
  assign csr_wd_o       = main_q.csr_wd;
  assign instret_incr_o = out_fire;
  assign retired_cnt_o  = retired_cnt_q;
  assign occupancy_o    = state_q;

endmodule

// File: tb/tb_lsu_wb_pipe.sv
// Directed bench for lsu_wb_pipe with a 4-bit retire counter so wrap-around is reachable.
module tb_lsu_wb_pipe;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned GPR_AW = 5;
  localparam int unsigned CSR_AW = 12;
  localparam int unsigned CNT_W  = 4;

  logic              clk_i = 1'b0;
  logic              n_rst_i = 1'b0;
  logic              flush_i = 1'b0;
  logic              in_valid_i = 1'b0;
  logic              in_ready_o;
  logic              rd_we_i = 1'b0;
  logic [GPR_AW-1:0] rd_wa_i = '0;
  logic [DATA_W-1:0] rd_wd_i = '0;
  logic              csr_we_i = 1'b0;
  logic [CSR_AW-1:0] csr_wa_i = '0;
  logic [DATA_W-1:0] csr_wd_i = '0;
  logic              out_valid_o;
  logic              out_ready_i = 1'b0;
  logic              rd_we_o;
  logic [GPR_AW-1:0] rd_wa_o;
  logic [DATA_W-1:0] rd_wd_o;
  logic              csr_we_o;
  logic [CSR_AW-1:0] csr_wa_o;
  logic [DATA_W-1:0] csr_wd_o;
  logic              instret_incr_o;
  logic [CNT_W-1:0]  retired_cnt_o;
  logic [1:0]        occupancy_o;

  int total = 0;
  int bad   = 0;

  always #5 clk_i = ~clk_i;

  lsu_wb_pipe #(
    .DATA_W     (DATA_W),
    .GPR_AW     (GPR_AW),
    .CSR_AW     (CSR_AW),
    .CNT_W      (CNT_W),
    .X0_SUPPRESS(1'b1)
  ) dut (
    .clk_i         (clk_i),
    .n_rst_i       (n_rst_i),
    .flush_i       (flush_i),
    .in_valid_i    (in_valid_i),
    .in_ready_o    (in_ready_o),
    .rd_we_i       (rd_we_i),
    .rd_wa_i       (rd_wa_i),
    .rd_wd_i       (rd_wd_i),
    .csr_we_i      (csr_we_i),
    .csr_wa_i      (csr_wa_i),
    .csr_wd_i      (csr_wd_i),
    .out_valid_o   (out_valid_o),
    .out_ready_i   (out_ready_i),
    .rd_we_o       (rd_we_o),
    .rd_wa_o       (rd_wa_o),
    .rd_wd_o       (rd_wd_o),
    .csr_we_o      (csr_we_o),
    .csr_wa_o      (csr_wa_o),
    .csr_wd_o      (csr_wd_o),
    .instret_incr_o(instret_incr_o),
    .retired_cnt_o (retired_cnt_o),
    .occupancy_o   (occupancy_o)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic drive(input logic v, input logic [GPR_AW-1:0] wa, input logic [DATA_W-1:0] wd);
    in_valid_i = v;
    rd_we_i    = v;
    rd_wa_i    = wa;
    rd_wd_i    = wd;
  endtask

  initial begin
    // Reset state, checked with no clock edge involved.
    #3;
    check("rst_in_ready", in_ready_o, 0);
    check("rst_out_valid", out_valid_o, 0);
    check("rst_occ", occupancy_o, 0);
    check("rst_cnt", retired_cnt_o, 0);
    check("rst_incr", instret_incr_o, 0);
    #9 n_rst_i = 1'b1;
    check("rst_ready_held", in_ready_o, 0);
    step();
    check("ready_after_rst", in_ready_o, 1);

    // Streaming 8 payloads back to back.
    out_ready_i = 1'b1;
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, GPR_AW'(i + 1), DATA_W'(32'h100 + i));
      if (i == 0) check("stream_pre_valid", out_valid_o, 0);
      step();
      check($sformatf("stream_valid%0d", i), out_valid_o, 1);
      check($sformatf("stream_wd%0d", i), rd_wd_o, 64'h100 + 64'(i));
      check($sformatf("stream_incr%0d", i), instret_incr_o, 1);
    end
    drive(1'b0, '0, '0);
    step();
    check("stream_end_valid", out_valid_o, 0);
    check("stream_cnt", retired_cnt_o, 8);

    // Backpressure: A and B buffered, then drained in order.
    out_ready_i = 1'b0;
    drive(1'b1, 5'd3, 32'h11);
    csr_we_i = 1'b1;
    csr_wa_i = 12'h305;
    csr_wd_i = 32'hCAFE;
    step();
    drive(1'b1, 5'd4, 32'h22);
    csr_we_i = 1'b0;
    step();
    drive(1'b0, '0, '0);
    check("bp_occ", occupancy_o, 2);
    check("bp_ready", in_ready_o, 0);
    check("bp_wa", rd_wa_o, 3);
    check("bp_wd", rd_wd_o, 64'h11);
    check("bp_csr_we", csr_we_o, 1);
    check("bp_csr_wa", csr_wa_o, 64'h305);
    check("bp_csr_wd", csr_wd_o, 64'hCAFE);
    check("bp_no_incr", instret_incr_o, 0);
    step();
    check("bp_hold_wd", rd_wd_o, 64'h11);
    out_ready_i = 1'b1;
    #1;
    check("bp_a_incr", instret_incr_o, 1);
    step();
    check("bp_b_wa", rd_wa_o, 4);
    check("bp_b_wd", rd_wd_o, 64'h22);
    check("bp_b_csr_we", csr_we_o, 0);
    check("bp_b_occ", occupancy_o, 1);
    check("bp_b_ready", in_ready_o, 1);
    step();
    check("bp_drain_occ", occupancy_o, 0);
    check("bp_cnt", retired_cnt_o, 10);

    // Write to x0 is suppressed but still retires.
    drive(1'b1, 5'd0, 32'h55);
    step();
    drive(1'b0, '0, '0);
    check("x0_we", rd_we_o, 0);
    check("x0_valid", out_valid_o, 1);
    check("x0_incr", instret_incr_o, 1);
    step();
    check("x0_cnt", retired_cnt_o, 11);

    // Flush in TWO with a simultaneous input: everything dropped.
    out_ready_i = 1'b0;
    drive(1'b1, 5'd5, 32'h33);
    step();
    drive(1'b1, 5'd6, 32'h44);
    step();
    check("fl_occ_pre", occupancy_o, 2);
    drive(1'b1, 5'd7, 32'h77);
    flush_i = 1'b1;
    step();
    flush_i = 1'b0;
    drive(1'b0, '0, '0);
    check("fl_occ", occupancy_o, 0);
    check("fl_valid", out_valid_o, 0);
    check("fl_ready", in_ready_o, 1);
    check("fl_we_cleared", rd_wa_o, 0);
    out_ready_i = 1'b1;
    step();
    check("fl_no_leak", out_valid_o, 0);
    check("fl_cnt", retired_cnt_o, 11);

    // Flush coincident with an output fire still counts that retire.
    drive(1'b1, 5'd8, 32'h88);
    step();
    drive(1'b0, '0, '0);
    flush_i = 1'b1;
    step();
    flush_i = 1'b0;
    check("flret_occ", occupancy_o, 0);
    check("flret_cnt", retired_cnt_o, 12);

    // Five more retires bring the total to 17, wrapping the 4-bit counter to 1.
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 5'd9, DATA_W'(i));
      step();
    end
    drive(1'b0, '0, '0);
    step();
    check("wrap_cnt", retired_cnt_o, 1);

    // Asynchronous reset between edges while in ONE.
    out_ready_i = 1'b0;
    drive(1'b1, 5'd10, 32'hAA);
    step();
    drive(1'b0, '0, '0);
    check("ar_pre_valid", out_valid_o, 1);
    out_ready_i = 1'b1;
    #2 n_rst_i = 1'b0;
    #1;
    check("ar_valid", out_valid_o, 0);
    check("ar_cnt", retired_cnt_o, 0);
    check("ar_incr", instret_incr_o, 0);
    check("ar_occ", occupancy_o, 0);
    check("ar_ready", in_ready_o, 0);
    check("ar_wd", rd_wd_o, 0);
    @(negedge clk_i);
    n_rst_i = 1'b1;
    step();
    check("ar_ready_rise", in_ready_o, 1);
    check("ar_cnt_hold", retired_cnt_o, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
